// File: rtl/atomic_counter_reader.sv
// atomic_counter_reader
//   Bus-side initiator for the 64-bit atomic event counter. It issues the two-access 32-bit
//   read pair: the first access is atomic and returns the low word while the counter snapshots
//   the high word, and the second access returns that snapshot. The module reassembles a
//   coherent 64-bit sample and reports the delta since the previous sample. Reads start on a
//   software command or on the internal periodic poll timer.
//
// Parameters
//   POLL_INTERVAL   cycles between poll ticks while poll_en_i=1 (>=2)
//   TIMEOUT_CYCLES  max wait cycles for ack_i per access (only with ACR_TIMEOUT_EN)
//
// Ports
//   clk        in   clock, all flops on posedge
//   reset      in   asynchronous, active-high reset
//   start_i    in   one-shot read command, ignored while busy_o=1
//   poll_en_i  in   enables periodic reads
//   busy_o     out  read sequence in progress
//   req_o      out  registered request to counter
//   atomic_o   out  registered, marks the first access of the pair
//   ack_i      in   counter acknowledge, one cycle after req_o
//   count_i    in   counter read data, valid with ack_i
//   data_o     out  last complete sample {hi, lo}
//   delta_o    out  data_o minus previous sample, modulo 2^64
//   valid_o    out  one-cycle pulse, data_o/delta_o updated
//   err_o      out  one-cycle pulse, sequence aborted on timeout
//
// Configuration
//   ACR_TIMEOUT_EN  when defined, each WAIT state aborts after TIMEOUT_CYCLES cycles without
//                   ack_i. When undefined, WAIT states hold indefinitely and err_o is 0.

module atomic_counter_reader #(
   parameter int unsigned POLL_INTERVAL  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        poll_en_i,
   output logic        busy_o,
   output logic        req_o,
   output logic        atomic_o,
   input  logic        ack_i,
   input  logic [31:0] count_i,
   output logic [63:0] data_o,
   output logic [63:0] delta_o,
   output logic        valid_o,
   output logic        err_o
);

   localparam int unsigned TimerW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StReqLo,
      StWaitLo,
      StReqHi,
      StWaitHi,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [31:0]         lo_q, hi_q;
   logic [63:0]         data_q, delta_q;
   logic                valid_q, req_q, atomic_q;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic                pend_q, pend_d;
   logic                launch, timer_run, tick, timeout;

   assign busy_o   = (state_q != StIdle);
   assign req_o    = req_q;
   assign atomic_o = atomic_q;
   assign data_o   = data_q;
   assign delta_o  = delta_q;
   assign valid_o  = valid_q;

   // The timer is frozen while a poll is pending or a read is in flight, so a poll-driven read
   // blocks the timer and back-to-back polls are spaced POLL_INTERVAL plus the read length.
   always_comb begin
      launch    = (state_q == StIdle) && (start_i || pend_q);
      timer_run = poll_en_i && !busy_o && !pend_q;
      tick      = timer_run && (timer_q == TimerW'(POLL_INTERVAL - 1));
      timer_d   = timer_q;
      pend_d    = pend_q;
      if (!poll_en_i) begin
         timer_d = '0;
         pend_d  = 1'b0;
      end else begin
         if (timer_run) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
         end
         // A tick coinciding with a start launch is consumed by that same launch.
         pend_d = (pend_q || tick) && !launch;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (launch) state_d = StReqLo;
         StReqLo:  state_d = StWaitLo;
         StWaitLo: begin
            if (ack_i)        state_d = StReqHi;
            else if (timeout) state_d = StIdle;
         end
         StReqHi:  state_d = StWaitHi;
         StWaitHi: begin
            if (ack_i)        state_d = StDone;
            else if (timeout) state_d = StIdle;
         end
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // data_q doubles as the previous sample: both only ever change together in StDone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         lo_q     <= '0;
         hi_q     <= '0;
         data_q   <= '0;
         delta_q  <= '0;
         valid_q  <= 1'b0;
         req_q    <= 1'b0;
         atomic_q <= 1'b0;
         timer_q  <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         pend_q   <= pend_d;
         valid_q  <= (state_q == StDone);
         req_q    <= (state_d == StReqLo) || (state_d == StReqHi);
         atomic_q <= (state_d == StReqLo);
         if (state_q == StWaitLo && ack_i) lo_q <= count_i;
         if (state_q == StWaitHi && ack_i) hi_q <= count_i;
         if (state_q == StDone) begin
            data_q  <= {hi_q, lo_q};
            delta_q <= {hi_q, lo_q} - data_q;
         end
      end
   end

`ifdef ACR_TIMEOUT_EN
   localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WaitW-1:0] wait_q, wait_d;
   logic             err_q;
   logic             in_wait;

   always_comb begin
      in_wait = (state_q == StWaitLo) || (state_q == StWaitHi);
      timeout = in_wait && !ack_i && (wait_q == WaitW'(TIMEOUT_CYCLES - 1));
      // Restart on every WAIT entry; count only while still waiting.
      wait_d  = (in_wait && !ack_i && !timeout) ? wait_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= timeout;
      end
   end

   assign err_o = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout            = 1'b0;
   assign err_o              = 1'b0;
`endif

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Directed bench for atomic_counter_reader. A behavioural responder models the counter:
// an atomic request snapshots the whole 64-bit value and returns the low word, the following
// request returns the snapshotted high word, each one cycle after req_o.

module tb_atomic_counter_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic        poll_en_i;
   logic        busy_o;
   logic        req_o;
   logic        atomic_o;
   logic        ack_i = 1'b0;
   logic [31:0] count_i = '0;
   logic [63:0] data_o;
   logic [63:0] delta_o;
   logic        valid_o;
   logic        err_o;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [63:0] cnt = '0;       // modelled counter value
   logic [63:0] snap = '0;      // value latched by the last atomic access
   logic [63:0] prev_exp = '0;  // expected previous sample
   logic        ack_en = 1'b1;
   logic        pend_ack = 1'b0;
   logic [31:0] pend_data = '0;

   atomic_counter_reader #(
      .POLL_INTERVAL (16),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start_i),
      .poll_en_i(poll_en_i),
      .busy_o   (busy_o),
      .req_o    (req_o),
      .atomic_o (atomic_o),
      .ack_i    (ack_i),
      .count_i  (count_i),
      .data_o   (data_o),
      .delta_o  (delta_o),
      .valid_o  (valid_o),
      .err_o    (err_o)
   );

   always #5 clk = ~clk;

   // Counter responder.
   always begin
      @(posedge clk);
      #1;
      ack_i = 1'b0;
      if (pend_ack && ack_en) begin
         ack_i   = 1'b1;
         count_i = pend_data;
      end
      pend_ack = 1'b0;
      if (req_o === 1'b1) begin
         pend_ack = 1'b1;
         if (atomic_o === 1'b1) begin
            snap      = cnt;
            pend_data = cnt[31:0];
         end else begin
            pend_data = snap[63:32];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_checks++;
      if (obs !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max_cyc, input bit inc, output bit got, output int cyc);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < max_cyc) begin
         step();
         cyc++;
         if (inc) cnt = cnt + 1;
         if (valid_o === 1'b1) got = 1'b1;
      end
   endtask

   task automatic do_read(input string tag, input bit inc);
      bit got;
      int cyc;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      wait_valid(20, inc, got, cyc);
      check_eq({tag, "_valid_seen"}, 64'(got), 64'd1);
      check_eq({tag, "_data"}, data_o, snap);
      check_eq({tag, "_delta"}, delta_o, snap - prev_exp);
      prev_exp = snap;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit got;
      int cyc;
      int nvalid;
      int first_at;

      reset     = 1'b1;
      start_i   = 1'b0;
      poll_en_i = 1'b0;
      step();
      step();
      check_eq("rst_busy", 64'(busy_o), 64'd0);
      check_eq("rst_req", 64'(req_o), 64'd0);
      check_eq("rst_atomic", 64'(atomic_o), 64'd0);
      check_eq("rst_valid", 64'(valid_o), 64'd0);
      check_eq("rst_err", 64'(err_o), 64'd0);
      check_eq("rst_data", data_o, 64'd0);
      check_eq("rst_delta", delta_o, 64'd0);
      reset = 1'b0;
      step();

      // 1: single read, cycle-exact timing.
      cnt     = 64'h0000_0001_FFFF_FFF0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check_eq("t1_req_t1", 64'(req_o), 64'd1);
      check_eq("t1_atomic_t1", 64'(atomic_o), 64'd1);
      check_eq("t1_busy_t1", 64'(busy_o), 64'd1);
      step();
      check_eq("t1_req_t2", 64'(req_o), 64'd0);
      step();
      check_eq("t1_req_t3", 64'(req_o), 64'd1);
      check_eq("t1_atomic_t3", 64'(atomic_o), 64'd0);
      step();
      step();
      check_eq("t1_valid_t5", 64'(valid_o), 64'd0);
      step();
      check_eq("t1_valid_t6", 64'(valid_o), 64'd1);
      check_eq("t1_data", data_o, 64'h0000_0001_FFFF_FFF0);
      check_eq("t1_delta", delta_o, 64'h0000_0001_FFFF_FFF0);
      step();
      check_eq("t1_valid_t7", 64'(valid_o), 64'd0);
      check_eq("t1_busy_t7", 64'(busy_o), 64'd0);
      check_eq("t1_data_hold", data_o, 64'h0000_0001_FFFF_FFF0);
      prev_exp = 64'h0000_0001_FFFF_FFF0;

      // 2: counter running across the 32-bit carry; sample stays coherent.
      cnt = 64'h0000_0000_FFFF_FFFF;
      do_read("t2a", 1'b1);
      check_eq("t2a_coherent",
               64'((data_o == 64'h0000_0000_FFFF_FFFF) ||
                   (data_o[63:32] == 32'd1 && data_o[31:8] == 24'd0)), 64'd1);
      cnt = 64'h0000_0000_FFFF_FFFE;
      do_read("t2b", 1'b1);
      check_eq("t2b_coherent",
               64'((data_o[63:32] == 32'd0 && data_o[31:0] >= 32'hFFFF_FFFE) ||
                   (data_o[63:32] == 32'd1 && data_o[31:8] == 24'd0)), 64'd1);

      // 3: delta of 10 events; start while busy ignored.
      cnt = 64'h0000_0002_0000_0100;
      do_read("t3a", 1'b0);
      cnt     = cnt + 64'd10;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      wait_valid(20, 1'b0, got, cyc);
      check_eq("t3b_valid_seen", 64'(got), 64'd1);
      check_eq("t3b_delta", delta_o, 64'd10);
      check_eq("t3b_data", data_o, 64'h0000_0002_0000_010A);
      prev_exp = 64'h0000_0002_0000_010A;
      nvalid   = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (valid_o === 1'b1) nvalid++;
      end
      check_eq("t3_busy_ignored", 64'(nvalid), 64'd0);
      check_eq("t3_idle", 64'(busy_o), 64'd0);

      // 4: periodic polling every 22 cycles; start on tick gives one read.
      cnt       = 64'h0000_0003_0000_0003;
      poll_en_i = 1'b1;
      wait_valid(40, 1'b0, got, cyc);
      check_eq("t4_first_poll", 64'(got), 64'd1);
      check_eq("t4_poll_data", data_o, 64'h0000_0003_0000_0003);
      wait_valid(40, 1'b0, got, cyc);
      check_eq("t4_period_a", 64'(cyc), 64'd22);
      wait_valid(40, 1'b0, got, cyc);
      check_eq("t4_period_b", 64'(cyc), 64'd22);
      check_eq("t4_poll_delta", delta_o, 64'd0);
      for (int i = 0; i < 15; i++) step();
      start_i = 1'b1;
      step();
      start_i  = 1'b0;
      nvalid   = 0;
      first_at = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (valid_o === 1'b1) begin
            nvalid++;
            if (first_at == 0) first_at = i;
         end
      end
      check_eq("t4_merge_count", 64'(nvalid), 64'd1);
      check_eq("t4_merge_latency", 64'(first_at), 64'd5);
      poll_en_i = 1'b0;
      step();
      step();
      prev_exp = 64'h0000_0003_0000_0003;

      // 5: reset during WAIT_HI.
      cnt     = 64'h0000_0005_0000_0007;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      step();
      step();
      check_eq("t5_busy_pre", 64'(busy_o), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t5_req_async", 64'(req_o), 64'd0);
      check_eq("t5_busy_async", 64'(busy_o), 64'd0);
      step();
      step();
      reset  = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (valid_o === 1'b1) nvalid++;
      end
      check_eq("t5_no_valid", 64'(nvalid), 64'd0);
      check_eq("t5_data_cleared", data_o, 64'd0);
      prev_exp = 64'd0;
      do_read("t5_after", 1'b0);

      // 6: responder never acknowledges.
      ack_en  = 1'b0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
`ifdef ACR_TIMEOUT_EN
      for (int i = 0; i < 8; i++) step();
      check_eq("t6_err_early", 64'(err_o), 64'd0);
      check_eq("t6_busy_wait", 64'(busy_o), 64'd1);
      step();
      check_eq("t6_err_pulse", 64'(err_o), 64'd1);
      check_eq("t6_busy_abort", 64'(busy_o), 64'd0);
      check_eq("t6_no_valid", 64'(valid_o), 64'd0);
      check_eq("t6_data_kept", data_o, prev_exp);
      step();
      check_eq("t6_err_one_cycle", 64'(err_o), 64'd0);
`else
      for (int i = 0; i < 30; i++) step();
      check_eq("t6_busy_hold", 64'(busy_o), 64'd1);
      check_eq("t6_err_zero", 64'(err_o), 64'd0);
      check_eq("t6_data_kept", data_o, prev_exp);
`endif
      ack_en = 1'b1;
      reset  = 1'b1;
      step();
      reset = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
